// File: rtl/jolt80_cpu.sv
// jolt80_cpu: multi-cycle 8-bit CPU, 16-bit instructions, req/ready memory port with registered outputs
module jolt80_cpu (
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    input  logic        data_ready,
    input  logic [15:0] temp_data_in,
    output logic [15:0] temp_data_out,
    output logic [15:0] data_inout_addr,
    output logic        data_acc_sz,
    output logic        data_inout_we,
    output logic        req_rdwr,
    output logic [7:0]  debug_vec
);
    typedef enum logic [1:0] {FETCH, FWAIT, EXEC, MWAIT} state_t;
    state_t state, state_n;
    logic [7:0] r [16];
    logic [15:0] pc, ipc, ir, rap, rbp, conds;
    logic z, c, n, v, ie, irq, take, is_add, is_sub, is_log, is_mem;
    logic [3:0] op, ra_i, rb_i;
    logic [7:0] imm, a_val, b_val, opnd, alu;
    logic [8:0] sum, dif;
    assign op = ir[15:12];
    assign ra_i = ir[11:8];
    assign rb_i = ir[7:4];
    assign imm = ir[7:0];
    assign a_val = r[ra_i];
    assign b_val = r[rb_i];
    assign opnd = (op == 4'h7 || op == 4'h8) ? imm : b_val;
    assign sum = {1'b0, a_val} + {1'b0, opnd};
    assign dif = {1'b0, a_val} - {1'b0, opnd};
    assign rap = {r[{ra_i[3:1], 1'b1}], r[{ra_i[3:1], 1'b0}]};
    assign rbp = {r[{rb_i[3:1], 1'b1}], r[{rb_i[3:1], 1'b0}]};
    assign is_add = op == 4'h0 || op == 4'h7;
    assign is_sub = op == 4'h1 || op == 4'h8;
    assign is_log = op == 4'h2 || op == 4'h3 || op == 4'h4;
    assign is_mem = op == 4'h9 || op == 4'hA;
    assign irq = ie && interrupt;
    // branch condition table indexed by the a field; 10-15 never taken
    assign conds = {6'b0, c & ~z, ~v, v, ~n, n, ~c, c, ~z, z, 1'b1};
    assign take = conds[ra_i];
    assign debug_vec = r[0];

    always_comb begin
        alu = a_val;
        case (op)
            4'h0, 4'h7: alu = sum[7:0];
            4'h1, 4'h8: alu = dif[7:0];
            4'h2:       alu = a_val & b_val;
            4'h3:       alu = a_val | b_val;
            4'h4:       alu = a_val ^ b_val;
            4'h5:       alu = b_val;
            4'h6:       alu = imm;
            default:    alu = a_val;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            FETCH: state_n = irq ? FETCH : FWAIT;
            FWAIT: state_n = data_ready ? EXEC : FWAIT;
            EXEC:  state_n = is_mem ? MWAIT : FETCH;
            MWAIT: state_n = data_ready ? FETCH : MWAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc <= 16'h0000;
            ipc <= 16'h0000;
            ir <= 16'h0000;
            {z, c, n, v, ie} <= 5'b0;
            for (int i = 0; i < 16; i++) r[i] <= 8'h00;
            req_rdwr <= 1'b0;
            data_inout_we <= 1'b0;
            data_inout_addr <= 16'h0000;
            data_acc_sz <= 1'b1;
            temp_data_out <= 16'h0000;
        end else begin
            state <= state_n;
            case (state)
                FETCH: begin
                    if (irq) begin
                        ipc <= pc;
                        pc <= 16'h0010;
                        ie <= 1'b0;
                    end else begin
                        req_rdwr <= 1'b1;
                        data_inout_addr <= pc;
                        data_acc_sz <= 1'b1;
                        data_inout_we <= 1'b0;
                    end
                end
                FWAIT: begin
                    if (data_ready) begin
                        ir <= temp_data_in;
                        pc <= pc + 16'd2;
                        req_rdwr <= 1'b0;
                        data_inout_we <= 1'b0;
                    end
                end
                EXEC: begin
                    if (op <= 4'h7) r[ra_i] <= alu;
                    if (is_add || is_sub || is_log) begin
                        z <= alu == 8'h00;
                        n <= alu[7];
                    end
                    if (is_add) begin
                        c <= sum[8];
                        v <= (a_val[7] == opnd[7]) && (sum[7] != a_val[7]);
                    end
                    if (is_sub) begin
                        c <= ~dif[8];
                        v <= (a_val[7] != opnd[7]) && (dif[7] != a_val[7]);
                    end
                    if (op == 4'hB && take) pc <= pc + {{7{imm[7]}}, imm, 1'b0};
                    if (op == 4'hC) pc <= rap;
                    if (op == 4'hE && ra_i == 4'h0) ie <= 1'b1;
                    if (op == 4'hE && ra_i == 4'h1) ie <= 1'b0;
                    if (op == 4'hE && ra_i == 4'h2) begin
                        pc <= ipc;
                        ie <= 1'b1;
                    end
                    if (is_mem) begin
                        req_rdwr <= 1'b1;
                        data_inout_addr <= rbp;
                        data_acc_sz <= 1'b0;
                        data_inout_we <= op == 4'hA;
                        temp_data_out <= {8'h00, a_val};
                    end
                end
                MWAIT: begin
                    if (data_ready) begin
                        if (op == 4'h9) r[ra_i] <= temp_data_in[7:0];
                        req_rdwr <= 1'b0;
                        data_inout_we <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jolt80_cpu.sv
// tb_jolt80_cpu: directed programs against a byte memory model with programmable ready latency.
module tb_jolt80_cpu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        interrupt = 1'b0;
    logic        data_ready;
    logic [15:0] temp_data_in;
    logic [15:0] temp_data_out;
    logic [15:0] data_inout_addr;
    logic        data_acc_sz;
    logic        data_inout_we;
    logic        req_rdwr;
    logic [7:0]  debug_vec;

    logic [7:0] mem [0:65535];
    int lat = 0;
    int cnt = 0;
    int n_checks = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    logic [15:0] wr_addr, wr_data;
    logic wr_sz;

    jolt80_cpu dut (
        .clk(clk),
        .reset(reset),
        .interrupt(interrupt),
        .data_ready(data_ready),
        .temp_data_in(temp_data_in),
        .temp_data_out(temp_data_out),
        .data_inout_addr(data_inout_addr),
        .data_acc_sz(data_acc_sz),
        .data_inout_we(data_inout_we),
        .req_rdwr(req_rdwr),
        .debug_vec(debug_vec)
    );

    always #5 clk = ~clk;

    assign data_ready = req_rdwr && (cnt >= lat);
    assign temp_data_in = data_acc_sz ? {mem[data_inout_addr | 16'h0001], mem[data_inout_addr & 16'hFFFE]}
                                      : {8'h00, mem[data_inout_addr]};

    // Memory writes and ready-latency counting are applied #1 after the edge the DUT sampled.
    task automatic tick();
        logic wr;
        logic [15:0] a, d;
        logic s;
        int cnt_n;
        wr = req_rdwr && data_ready && data_inout_we;
        a = data_inout_addr;
        d = temp_data_out;
        s = data_acc_sz;
        cnt_n = (req_rdwr && !data_ready) ? cnt + 1 : 0;
        @(posedge clk);
        #1;
        cnt = cnt_n;
        if (wr) begin
            mem[a] = d[7:0];
            wr_cnt++;
            wr_addr = a;
            wr_data = d;
            wr_sz = s;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [15:0] a, input logic [15:0] w);
        mem[a] = w[7:0];
        mem[a + 16'd1] = w[15:8];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic run_to(input string tag, input logic [15:0] a, output int cyc);
        logic found;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 2000) begin
            tick();
            cyc++;
            found = req_rdwr && !data_inout_we && data_acc_sz && data_inout_addr == a;
        end
        check(tag, {15'b0, found}, 16'h0001);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        // cpyi r0,0x7F; addi r0,0x01; halt
        put(16'h0000, 16'h607F);
        put(16'h0002, 16'h7001);
        put(16'h0004, 16'hB0FF);
        do_reset();
        check("reset_req", {15'b0, req_rdwr}, 16'h0000);
        check("reset_addr", data_inout_addr, 16'h0000);
        check("reset_sz", {15'b0, data_acc_sz}, 16'h0001);
        check("reset_dout", temp_data_out, 16'h0000);
        check("reset_dbg", {8'h00, debug_vec}, 16'h0000);
        run_to("t1_halt", 16'h0004, cyc);
        check("t1_cycles", cyc[15:0], 16'd7);
        check("t1_r0", {8'h00, debug_vec}, 16'h0080);
        check("t1_nvcz", {12'h000, dut.n, dut.v, dut.c, dut.z}, 16'h000C);

        // strb / ldrb through r2p = 0x0100
        put(16'h0000, 16'h6200);
        put(16'h0002, 16'h6301);
        put(16'h0004, 16'h61A5);
        put(16'h0006, 16'hA120);
        put(16'h0008, 16'h9020);
        put(16'h000A, 16'hB0FF);
        do_reset();
        run_to("t2_halt", 16'h000A, cyc);
        check("t2_cycles", cyc[15:0], 16'd18);
        check("t2_wr_cnt", wr_cnt[15:0], 16'd1);
        check("t2_wr_addr", wr_addr, 16'h0100);
        check("t2_wr_sz", {15'b0, wr_sz}, 16'h0000);
        check("t2_wr_data", wr_data, 16'h00A5);
        check("t2_r0", {8'h00, debug_vec}, 16'h00A5);

        // five wait cycles on the first fetch; addi must execute once
        lat = 5;
        put(16'h0000, 16'h7005);
        put(16'h0002, 16'hB0FF);
        do_reset();
        tick();
        check("t3_req_first", {15'b0, req_rdwr}, 16'h0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold", {req_rdwr, data_inout_addr[14:0]}, 16'h8000);
        end
        tick();
        check("t3_req_drop", {15'b0, req_rdwr}, 16'h0000);
        run_to("t3_halt", 16'h0002, cyc);
        check("t3_r0_once", {8'h00, debug_vec}, 16'h0005);
        lat = 0;

        // cpyi r0,3; L: addi r0,0xFF; bne L; halt
        put(16'h0000, 16'h6003);
        put(16'h0002, 16'h70FF);
        put(16'h0004, 16'hB2FE);
        put(16'h0006, 16'hB0FF);
        do_reset();
        run_to("t4_halt", 16'h0006, cyc);
        check("t4_cycles", cyc[15:0], 16'd22);
        check("t4_r0", {8'h00, debug_vec}, 16'h0000);
        check("t4_nvcz", {12'h000, dut.n, dut.v, dut.c, dut.z}, 16'h0003);

        // ei; addi r0,1; halt -- ISR at 0x10: cpyi r1,0x55; reti
        put(16'h0000, 16'hE000);
        put(16'h0002, 16'h7001);
        put(16'h0004, 16'hB0FF);
        put(16'h0010, 16'h6155);
        put(16'h0012, 16'hE200);
        interrupt = 1'b1;
        do_reset();
        tick();
        check("t5_ie0_ignored", {req_rdwr, data_inout_addr[14:0]}, 16'h8000);
        run_to("t5_vector", 16'h0010, cyc);
        check("t5_vec_cycles", cyc[15:0], 16'd4);
        check("t5_ie_cleared", {15'b0, dut.ie}, 16'h0000);
        check("t5_ipc", dut.ipc, 16'h0002);
        interrupt = 1'b0;
        run_to("t5_halt", 16'h0004, cyc);
        check("t5_r0", {8'h00, debug_vec}, 16'h0001);
        check("t5_r1", {8'h00, dut.r[1]}, 16'h0055);
        check("t5_ie_set", {15'b0, dut.ie}, 16'h0001);

        // reset while the first fetch is waiting
        lat = 5;
        put(16'h0000, 16'h7005);
        put(16'h0002, 16'hB0FF);
        do_reset();
        tick();
        tick();
        tick();
        check("t6_in_fwait", {15'b0, req_rdwr}, 16'h0001);
        reset = 1'b1;
        tick();
        check("t6_reset_req", {15'b0, req_rdwr}, 16'h0000);
        check("t6_reset_sz", {15'b0, data_acc_sz}, 16'h0001);
        reset = 1'b0;
        tick();
        check("t6_refetch", {req_rdwr, data_inout_addr[14:0]}, 16'h8000);
        run_to("t6_halt", 16'h0002, cyc);
        check("t6_r0", {8'h00, debug_vec}, 16'h0005);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jolt80_cpu.md
# jolt80_cpu

Compact 8-bit CPU core with a 16-bit address space, sixteen 8-bit registers and 16-bit instructions. It sits between the system clock/reset and a shared byte/halfword memory port. The memory port uses a request/ready handshake, so memory latency is arbitrary. An `interrupt` input and a `debug_vec` observation output are also provided.

## Interface
- No parameters.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `interrupt`  in  1  level interrupt request, sampled only at instruction boundaries.
- `data_ready`  in  1  memory has completed the current request.
- `temp_data_in`  in  16  read data; 8-bit reads use bits [7:0].
- `temp_data_out`  out  16  write data; 8-bit writes use bits [7:0].
- `data_inout_addr`  out  16  byte address.
- `data_acc_sz`  out  1  access size: 0 = 8-bit, 1 = 16-bit.
- `data_inout_we`  out  1  1 = write, 0 = read.
- `req_rdwr`  out  1  memory request strobe.
- `debug_vec`  out  8  continuous copy of r0.

## Operation
- State: r0–r15 (8 bits), 16-bit pc, flags Z/C/N/V, ie (interrupt enable), 16-bit ipc.
- A register pair rXp is {r(X+1), rX}. X must be even; bit 0 of X is ignored.
- Memory is little-endian. A 16-bit access at byte address A returns byte A in [7:0]; A must be even.
- Instruction word fields: op=[15:12], a=[11:8], b=[7:4], imm=[7:0].
- 0 `add ra,rb`: ra+=rb; sets Z,N,C (carry out),V (signed overflow).
- 1 `sub ra,rb`: ra-=rb; sets Z,N,C (1 = no borrow),V.
- 2 `and`, 3 `orr`, 4 `xor` (ra op= rb): set Z,N; C and V unchanged.
- 5 `cpy ra,rb` and 6 `cpyi ra,imm`: no flag change.
- 7 `addi ra,imm`: flags as `add`.
- 8 `cmpi ra,imm`: flags as `sub`; ra not written.
- 9 `ldrb ra,[rbp]`: 8-bit read into ra.
- A `strb ra,[rbp]`: 8-bit write of ra.
- B `bcc`: a = condition, imm = signed word offset; taken → pc = pc_after_fetch + sext(imm)·2.
  - Conditions: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 !N, 7 V, 8 !V, 9 C&!Z, 10–15 never.
- C `jmp rap`: pc = rap.
- E system group, selected by a: 0 `ei` (ie=1), 1 `di` (ie=0), 2 `reti` (pc=ipc, ie=1), others nop.
- D and F: nop.
- Interrupt entry: at an instruction boundary with ie=1 and interrupt=1, the CPU sets ipc=pc, pc=0x0010, ie=0. No fetch occurs in that cycle.
- Register writes to r0 are visible on `debug_vec` the cycle after execute.

## Timing
- States: FETCH → FWAIT → EXEC → (MWAIT for ldrb/strb) → FETCH. The interrupt check is done in FETCH.
- FETCH:
  - drives req_rdwr=1, addr=pc, acc_sz=1, we=0;
  - next state FWAIT.
- FWAIT:
  - holds all request outputs stable until data_ready=1;
  - in that cycle latches the instruction, sets pc+=2, deasserts req_rdwr and we, and moves to EXEC.
- EXEC:
  - non-memory ops complete here; next state FETCH;
  - ldrb/strb drive the request (addr=rbp, acc_sz=0, we, data_out={8'h00,ra}) and move to MWAIT.
- MWAIT:
  - holds the request until data_ready=1;
  - then writes ra (ldrb), deasserts req_rdwr and we, and moves to FETCH.
- Minimum cost: 3 cycles for ALU/branch instructions, 4 for memory instructions, when data_ready is already high.
- Outputs change only on clk edges. data_ready is sampled synchronously; outputs are never dropped before ready.
- Reset, including mid-request:
  - next edge: state=FETCH, pc=0, all registers=0, flags=0, ie=0, ipc=0;
  - outputs: req_rdwr=0, we=0, addr=0, acc_sz=1, temp_data_out=0;
  - any in-flight access is abandoned.
- Arithmetic wraps modulo 256; pc wraps modulo 65536.

## Test plan
- Reset, then program `cpyi r0,0x7F; addi r0,0x01` with zero-latency memory → debug_vec=0x80, N=1, V=1, C=0, Z=0; req_rdwr=0 on the reset edge.
- `cpyi r2,0x00; cpyi r3,0x01; cpyi r1,0xA5; strb r1,[r2p]; ldrb r0,[r2p]` → a write at 0x0100 with acc_sz=0, data_out=0x00A5; then debug_vec=0xA5.
- Memory with data_ready delayed 5 cycles → req_rdwr and addr held constant 5 cycles; instruction executes exactly once.
- `cpyi r0,3; L: addi r0,0xFF; bcc ne,L` → loop runs 3 times; ends with r0=0, Z=1, C=1.
- `ei` followed by interrupt=1 → next fetch at 0x0010, ie=0; `reti` resumes at the saved pc with ie=1. With ie=0 the interrupt is ignored.
- Assert reset during FWAIT → req_rdwr=0 next edge, then a fetch from 0x0000.
